// File: rtl/prbs4_chk_if.sv
// Serial PRBS receive-side bundle: bit stream and clear in, lock/error status out.
interface prbs4_chk_if #(
  parameter int CNT_W = 16
) ();
  logic             din;
  logic             din_vld;
  logic             clr;
  logic             lock;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  modport master (output din, din_vld, clr, input lock, err, err_cnt);
  modport slave  (input din, din_vld, clr, output lock, err, err_cnt);
endinterface

// File: rtl/prbs4_chk.sv
// PRBS-4 (x^4+x+1) checker: hunts for lock on the received stream, then free-runs a
// local generator and counts mismatches, dropping lock on a bad 16-bit block.
module prbs4_chk #(
  parameter int LOCK_CNT  = 8,
  parameter int ERR_LIMIT = 4,
  parameter int CNT_W     = 16
) (
  input logic        clk,
  input logic        res,
  prbs4_chk_if.slave bus
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state, state_n;
  logic [3:0]       h, h_n;
  logic [2:0]       fill, fill_n;
  logic [7:0]       match_cnt, match_n;
  logic [3:0]       blk_cnt, blk_cnt_n;
  logic [4:0]       blk_err, blk_err_n;
  logic [4:0]       blk_tot;
  logic             err_q, err_n;
  logic [CNT_W-1:0] err_cnt, cnt_n;
  logic             p;
  logic             miss;

  // The locked checker never loads received bits, so one line error costs one count.
  always_comb begin
    state_n   = state;
    h_n       = h;
    fill_n    = fill;
    match_n   = match_cnt;
    blk_cnt_n = blk_cnt;
    blk_err_n = blk_err;
    err_n     = 1'b0;
    cnt_n     = err_cnt;
    p         = h[0] ^ h[3];
    miss      = 1'b0;
    blk_tot   = blk_err;

    if (bus.din_vld) begin
      case (state)
        HUNT: begin
          h_n = {h[2:0], bus.din};
          if (fill != 3'd4) begin
            fill_n = fill + 3'd1;
          end else if ((bus.din == p) && (h != 4'b0000)) begin
            if (({1'b0, match_cnt} + 9'd1) == 9'(LOCK_CNT)) begin
              state_n   = LOCKED;
              match_n   = 8'd0;
              blk_cnt_n = 4'd0;
              blk_err_n = 5'd0;
            end else begin
              match_n = match_cnt + 8'd1;
            end
          end else begin
            match_n = 8'd0;
          end
        end
        LOCKED: begin
          h_n       = {h[2:0], p};
          blk_cnt_n = blk_cnt + 4'd1;
          miss      = (bus.din != p);
          err_n     = miss;
          blk_tot   = blk_err + {4'd0, miss};
          if (miss && (err_cnt != {CNT_W{1'b1}}))
            cnt_n = err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          // The block limit includes the current bit before the wrap clears it.
          if (blk_tot >= 5'(ERR_LIMIT)) begin
            state_n   = HUNT;
            h_n       = 4'b0000;
            fill_n    = 3'd0;
            match_n   = 8'd0;
            blk_cnt_n = 4'd0;
            blk_err_n = 5'd0;
          end else if (blk_cnt == 4'd15) begin
            blk_err_n = 5'd0;
          end else begin
            blk_err_n = blk_tot;
          end
        end
        default: state_n = HUNT;
      endcase
    end

    if (bus.clr)
      cnt_n = '0;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= HUNT;
      h         <= 4'b0000;
      fill      <= 3'd0;
      match_cnt <= 8'd0;
      blk_cnt   <= 4'd0;
      blk_err   <= 5'd0;
      err_q     <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      h         <= h_n;
      fill      <= fill_n;
      match_cnt <= match_n;
      blk_cnt   <= blk_cnt_n;
      blk_err   <= blk_err_n;
      err_q     <= err_n;
      err_cnt   <= cnt_n;
    end
  end

  assign bus.lock    = (state == LOCKED);
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt;

endmodule
